// File: rtl/histo_pkg.sv
// ---------------------------------------------------------------------------
// histo_pkg
// Shared constants and types for the grey-histogram path: the accumulator
// that fills the histogram RAM and the equaliser that reads it back.
// Contents:
//   - geometry (bins, pixel width, count width, frame size)
//   - CDF-to-LUT scaling constants and the threshold count
//   - equaliser FSM state encoding
//   - cdf_to_lut: rounds and clamps a CDF value into an 8-bit LUT entry
// ---------------------------------------------------------------------------
package histo_pkg;

    localparam int BINS          = 256;
    localparam int BIN_W         = 8;
    localparam int GREY_W        = 12;
    localparam int CNT_W         = 20;
    localparam int PIX_TOTAL     = 307200;
    localparam int SCALE_MUL     = 13926;
    localparam int SCALE_W       = 14;
    localparam int SCALE_SHIFT   = 24;
    localparam int THRESH_CNT    = 192000;
    localparam int SETTLE_CYCLES = 3;

    localparam int PROD_W = CNT_W + SCALE_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        BUILD  = 2'd2,
        DONE   = 2'd3
    } eq_state_t;

    // The full product is kept (no truncation) and an extra bit absorbs
    // the rounding half-LSB so the sum can never wrap.
    function automatic logic [BIN_W-1:0] cdf_to_lut(input logic [CNT_W-1:0] cdf);
        logic [PROD_W-1:0] prod;
        logic [PROD_W:0]   rounded;
        logic [PROD_W:0]   shifted;
        prod    = {{SCALE_W{1'b0}}, cdf} * PROD_W'(SCALE_MUL);
        rounded = {1'b0, prod} + ((PROD_W + 1)'(1) << (SCALE_SHIFT - 1));
        shifted = rounded >> SCALE_SHIFT;
        return (|shifted[PROD_W:BIN_W]) ? {BIN_W{1'b1}} : shifted[BIN_W-1:0];
    endfunction

endpackage

// File: rtl/hist_lut_ram.sv
// ---------------------------------------------------------------------------
// hist_lut_ram
// Double-banked 2x256x8 equalisation LUT. The bank bit is the MSB of the
// internal address. One write port (used for the shadow bank) and one
// registered read port (used for the active bank). Contents are not reset.
// Ports:
//   iPclk    clock
//   wr_en    write strobe
//   wr_bank  bank written
//   wr_addr  bin written
//   wr_data  LUT value written
//   rd_bank  bank read
//   rd_addr  bin read
//   rd_data  registered read data (one cycle after rd_addr)
// ---------------------------------------------------------------------------
module hist_lut_ram
    import histo_pkg::*;
(
    input  logic             iPclk,
    input  logic             wr_en,
    input  logic             wr_bank,
    input  logic [BIN_W-1:0] wr_addr,
    input  logic [BIN_W-1:0] wr_data,
    input  logic             rd_bank,
    input  logic [BIN_W-1:0] rd_addr,
    output logic [BIN_W-1:0] rd_data
);

    logic [BIN_W-1:0] mem [0:2*BINS-1];

    always_ff @(posedge iPclk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
        rd_data <= mem[{rd_bank, rd_addr}];
    end

endmodule

// File: rtl/histo_equalizer.sv
// ---------------------------------------------------------------------------
// histo_equalizer
// Consumer side of the per-frame grey histogram. During vertical blanking it
// streams all bins out of the histogram RAM, accumulates the CDF, writes an
// 8-bit equalisation LUT into the shadow bank and finds the threshold bin.
// On the next frame start the banks swap and every pixel is mapped through
// the new LUT with a fixed 2-cycle latency.
// Ports:
//   iPclk          pixel clock
//   iRST_N         asynchronous active-low reset
//   iFval/iDval    frame / pixel valid
//   iGrey          12-bit grey pixel
//   oHist_Rd_Addr  histogram RAM read address
//   iHist_Rd_Data  histogram RAM data, one cycle after the address
//   oGrey_Eq       equalised pixel (pass-through until the first swap)
//   oDval          iDval aligned with oGrey_Eq
//   oThresh        threshold bin of the last completed build
//   oLut_Valid     set after the first bank swap
//   oBuild_Abort   one-cycle pulse when a build is abandoned
// ---------------------------------------------------------------------------
module histo_equalizer
    import histo_pkg::*;
(
    input  logic              iPclk,
    input  logic              iRST_N,
    input  logic              iFval,
    input  logic              iDval,
    input  logic [GREY_W-1:0] iGrey,
    output logic [BIN_W-1:0]  oHist_Rd_Addr,
    input  logic [CNT_W-1:0]  iHist_Rd_Data,
    output logic [BIN_W-1:0]  oGrey_Eq,
    output logic              oDval,
    output logic [BIN_W-1:0]  oThresh,
    output logic              oLut_Valid,
    output logic              oBuild_Abort
);

    localparam logic [1:0] SETTLE_LAST = 2'(SETTLE_CYCLES - 1);

    eq_state_t        state;
    logic             fval_r;
    logic [1:0]       settle_cnt;
    logic             issuing;
    logic             data_valid;
    logic [BIN_W-1:0] kd;
    logic [CNT_W-1:0] cdf;
    logic             found;
    logic [BIN_W-1:0] thr_shadow;
    logic             active_bank;

    logic             fval_rise;
    logic             fval_fall;
    logic [CNT_W:0]   cdf_sum;
    logic [CNT_W-1:0] cdf_next;
    logic [BIN_W-1:0] lut_value;
    logic             lut_wr_en;
    logic [BIN_W-1:0] lut_rd_data;

    logic [BIN_W-1:0] grey_s1;
    logic             dval_s1;
    logic             valid_s1;
    logic             grey_low_unused;

    assign fval_rise = iFval & ~fval_r;
    assign fval_fall = ~iFval & fval_r;

    // CDF accumulates with saturation so a pathological histogram cannot wrap.
    assign cdf_sum   = {1'b0, cdf} + {1'b0, iHist_Rd_Data};
    assign cdf_next  = cdf_sum[CNT_W] ? {CNT_W{1'b1}} : cdf_sum[CNT_W-1:0];
    assign lut_value = cdf_to_lut(cdf_next);
    assign lut_wr_en = (state == BUILD) && data_valid && !fval_rise;

    // Only the bin index is used for the lookup; the low nibble is dropped.
    assign grey_low_unused = ^iGrey[GREY_W-BIN_W-1:0];

    hist_lut_ram u_lut_ram (
        .iPclk   (iPclk),
        .wr_en   (lut_wr_en),
        .wr_bank (~active_bank),
        .wr_addr (kd),
        .wr_data (lut_value),
        .rd_bank (active_bank),
        .rd_addr (iGrey[GREY_W-1 -: BIN_W]),
        .rd_data (lut_rd_data)
    );

    // Build controller. The read address runs one cycle ahead of the data,
    // so 'kd' carries the bin whose count is on iHist_Rd_Data this cycle.
    always_ff @(posedge iPclk or negedge iRST_N) begin
        if (!iRST_N) begin
            state         <= IDLE;
            fval_r        <= 1'b0;
            settle_cnt    <= 2'd0;
            issuing       <= 1'b0;
            data_valid    <= 1'b0;
            kd            <= '0;
            cdf           <= '0;
            found         <= 1'b0;
            thr_shadow    <= '0;
            active_bank   <= 1'b0;
            oHist_Rd_Addr <= '0;
            oThresh       <= '0;
            oLut_Valid    <= 1'b0;
            oBuild_Abort  <= 1'b0;
        end else begin
            fval_r       <= iFval;
            oBuild_Abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (fval_fall) begin
                        state      <= SETTLE;
                        settle_cnt <= 2'd0;
                    end
                end
                SETTLE: begin
                    if (fval_rise) begin
                        oBuild_Abort <= 1'b1;
                        state        <= IDLE;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state         <= BUILD;
                        oHist_Rd_Addr <= '0;
                        issuing       <= 1'b1;
                        data_valid    <= 1'b0;
                        cdf           <= '0;
                        found         <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt + 2'd1;
                    end
                end
                BUILD: begin
                    if (fval_rise) begin
                        oBuild_Abort <= 1'b1;
                        issuing      <= 1'b0;
                        data_valid   <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        if (data_valid) begin
                            cdf <= cdf_next;
                            if (!found && (cdf_next > CNT_W'(THRESH_CNT))) begin
                                thr_shadow <= kd;
                                found      <= 1'b1;
                            end
                            if (kd == {BIN_W{1'b1}}) begin
                                state <= DONE;
                            end
                        end
                        if (issuing) begin
                            data_valid <= 1'b1;
                            kd         <= oHist_Rd_Addr;
                            if (oHist_Rd_Addr == {BIN_W{1'b1}}) begin
                                issuing <= 1'b0;
                            end else begin
                                oHist_Rd_Addr <= oHist_Rd_Addr + 8'd1;
                            end
                        end else begin
                            data_valid <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    // A histogram that never crosses the threshold reports the top bin.
                    if (!found) begin
                        thr_shadow <= {BIN_W{1'b1}};
                    end
                    if (fval_rise) begin
                        active_bank <= ~active_bank;
                        oThresh     <= found ? thr_shadow : {BIN_W{1'b1}};
                        oLut_Valid  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Mapping pipeline: stage 1 is the LUT read, stage 2 selects LUT or
    // pass-through. The valid flag travels with the read so a swap and the
    // pass-through/LUT choice always refer to the same pixel.
    always_ff @(posedge iPclk or negedge iRST_N) begin
        if (!iRST_N) begin
            grey_s1  <= '0;
            dval_s1  <= 1'b0;
            valid_s1 <= 1'b0;
            oGrey_Eq <= '0;
            oDval    <= 1'b0;
        end else begin
            grey_s1  <= iGrey[GREY_W-1 -: BIN_W];
            dval_s1  <= iDval;
            valid_s1 <= oLut_Valid;
            oDval    <= dval_s1;
            oGrey_Eq <= valid_s1 ? lut_rd_data : grey_s1;
        end
    end

endmodule
